// File: rtl/obi_arb_pkg.sv
// Shared types for the two-to-one OBI memory arbiter.
// Covers the requester IDs and the lock state encoding.
package obi_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } obi_src_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin partner: the requester that did not win last time.
    function automatic obi_src_e other_src(input obi_src_e src);
        return (src == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    endfunction

endpackage

// File: rtl/obi_arb_checker.sv
// Simulation-side protocol checks for obi_mem_arbiter.
// A response arriving with nothing outstanding is dropped by the arbiter and flagged here.
module obi_arb_checker (
    input logic clk_i,
    input logic rst_i,
    input logic i_rvalid,
    input logic i_fifo_empty
);

    // Flag memory responses that have no matching granted request.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(i_rvalid && i_fifo_empty))
            else $warning("obi_mem_arbiter: rvalid with no outstanding transaction, response dropped");
        end
    end

endmodule

// File: rtl/obi_arb_src_fifo.sv
// In-order FIFO of requester IDs for granted transactions still awaiting rvalid.
// DEPTH must be a power of two so the pointers wrap naturally.
module obi_arb_src_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     i_push,
    input  obi_src_e i_push_src,
    input  logic     i_pop,
    output logic     o_full,
    output logic     o_empty,
    output obi_src_e o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    obi_src_e         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= SRC_INSTR;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_src;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-to-one OBI arbiter: instruction and data requesters share one memory port.
// Round-robin per transaction, address phase locked until granted, responses routed in order.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    busy_o
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    arb_state_e r_state;
    arb_state_e w_state_next;
    obi_src_e   r_lock_src;
    obi_src_e   w_lock_src_next;
    obi_src_e   r_last_src;
    obi_src_e   w_sel;
    obi_src_e   w_head;
    logic       w_sel_req;
    logic       w_grant;
    logic       w_pop;
    logic       w_fifo_full;
    logic       w_fifo_empty;

    // Source selection: a locked source wins, otherwise round-robin on contention.
    always_comb begin
        w_sel = SRC_INSTR;
        if (r_state == ARB_LOCKED) begin
            w_sel = r_lock_src;
        end else if (instr_req_i && data_req_i) begin
            w_sel = other_src(r_last_src);
        end else if (data_req_i) begin
            w_sel = SRC_DATA;
        end else begin
            w_sel = SRC_INSTR;
        end
    end

    assign w_sel_req = (w_sel == SRC_DATA) ? data_req_i : instr_req_i;
    // A full FIFO blocks the request even when a response pops it this cycle.
    assign mem_req_o = w_sel_req && !w_fifo_full;
    assign w_grant   = mem_gnt_i && mem_req_o && !rst_i;

    assign instr_gnt_o = w_grant && (w_sel == SRC_INSTR);
    assign data_gnt_o  = w_grant && (w_sel == SRC_DATA);

    // Request field muxing; instruction fetches are always full-word reads.
    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = {BE_W{1'b1}};
        mem_wdata_o = {DATA_WIDTH{1'b0}};
        if (w_sel == SRC_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end else begin
            mem_addr_o  = instr_addr_i;
            mem_we_o    = 1'b0;
            mem_be_o    = {BE_W{1'b1}};
            mem_wdata_o = {DATA_WIDTH{1'b0}};
        end
    end

    // Lock FSM next state: hold the selection while the memory inserts wait states.
    always_comb begin
        w_state_next    = r_state;
        w_lock_src_next = r_lock_src;
        case (r_state)
            ARB_IDLE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    w_state_next    = ARB_LOCKED;
                    w_lock_src_next = w_sel;
                end else begin
                    w_state_next    = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (mem_gnt_i) begin
                    w_state_next = ARB_IDLE;
                end else begin
                    w_state_next = ARB_LOCKED;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    // Lock state and latched source.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ARB_IDLE;
            r_lock_src <= SRC_INSTR;
        end else begin
            r_state    <= w_state_next;
            r_lock_src <= w_lock_src_next;
        end
    end

    // Last granted source; DATA at reset so the first contention goes to INSTR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_src <= SRC_DATA;
        end else if (w_grant) begin
            r_last_src <= w_sel;
        end else begin
            r_last_src <= r_last_src;
        end
    end

    assign w_pop = mem_rvalid_i && !w_fifo_empty;

    obi_arb_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_push     (w_grant),
        .i_push_src (w_sel),
        .i_pop      (w_pop),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_head     (w_head)
    );

    assign instr_rvalid_o = w_pop && (w_head == SRC_INSTR);
    assign data_rvalid_o  = w_pop && (w_head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign busy_o = !w_fifo_empty || mem_req_o;

    obi_arb_checker u_checker (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_rvalid     (mem_rvalid_i),
        .i_fifo_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: directed scenarios followed by random traffic,
// every output compared against a queue-based reference model each cycle.
module tb_obi_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          instr_req_i;
    logic          instr_gnt_o;
    logic [AW-1:0] instr_addr_i;
    logic          instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i;
    logic          data_gnt_o;
    logic [AW-1:0] data_addr_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [DW-1:0] data_wdata_i;
    logic          data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_req_o;
    logic          mem_gnt_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o;

    obi_mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = instruction, 1 = data.
    int q[$];
    int m_last;
    bit m_hold;
    int m_hold_src;
    int e_sel;
    bit e_req;
    bit e_gnt_i;
    bit e_gnt_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_last     = 1;
        m_hold     = 1'b0;
        m_hold_src = 0;
    endtask

    task automatic model_check();
        int  sel;
        bit  rv_i;
        bit  rv_d;
        if (m_hold)                          sel = m_hold_src;
        else if (instr_req_i && data_req_i)  sel = 1 - m_last;
        else if (data_req_i)                 sel = 1;
        else                                 sel = 0;
        e_sel   = sel;
        e_req   = ((sel == 1) ? data_req_i : instr_req_i) && (q.size() < MAXO);
        e_gnt_i = !rst_i && mem_gnt_i && e_req && (sel == 0);
        e_gnt_d = !rst_i && mem_gnt_i && e_req && (sel == 1);
        rv_i    = mem_rvalid_i && (q.size() > 0) && (q[0] == 0);
        rv_d    = mem_rvalid_i && (q.size() > 0) && (q[0] == 1);
        chk("mem_req", mem_req_o, e_req);
        chk("mem_addr", mem_addr_o, (sel == 1) ? data_addr_i : instr_addr_i);
        chk("mem_we", mem_we_o, (sel == 1) ? data_we_i : 1'b0);
        chk("mem_be", mem_be_o, (sel == 1) ? data_be_i : 4'hF);
        chk("mem_wdata", mem_wdata_o, (sel == 1) ? data_wdata_i : 32'h0);
        chk("instr_gnt", instr_gnt_o, e_gnt_i);
        chk("data_gnt", data_gnt_o, e_gnt_d);
        chk("instr_rvalid", instr_rvalid_o, rv_i);
        chk("data_rvalid", data_rvalid_o, rv_d);
        chk("instr_rdata", instr_rdata_o, mem_rdata_i);
        chk("data_rdata", data_rdata_o, mem_rdata_i);
        chk("busy", busy_o, (q.size() > 0) || e_req);
    endtask

    task automatic model_update();
        if (rst_i) begin
            model_clear();
        end else begin
            if (mem_rvalid_i && q.size() > 0) q.delete(0);
            if (e_gnt_i || e_gnt_d) begin
                q.push_back(e_sel);
                m_last = e_sel;
            end
            if (m_hold) begin
                if (mem_gnt_i) m_hold = 1'b0;
            end else if (e_req && !mem_gnt_i) begin
                m_hold     = 1'b1;
                m_hold_src = e_sel;
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk_i);
        model_check();
    endtask

    task automatic adv();
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    bit last_gi;
    bit last_gd;

    initial begin
        rst_i = 1'b1;
        instr_req_i = 1'b0; instr_addr_i = 32'h0;
        data_req_i = 1'b0; data_addr_i = 32'h0; data_we_i = 1'b0;
        data_be_i = 4'h0; data_wdata_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        model_clear();

        // Reset: request path combinational, grants suppressed.
        instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
        at_neg();
        chk("rst_mem_req", mem_req_o, 1'b1);
        chk("rst_instr_gnt", instr_gnt_o, 1'b0);
        chk("rst_busy", busy_o, 1'b1);
        adv();
        rst_i = 1'b0;

        // Instruction-only stream, responses one cycle after each grant.
        at_neg(); chk("t1_gnt0", instr_gnt_o, 1'b1); adv();
        instr_addr_i = 32'h84; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA0A0_0000;
        at_neg(); chk("t1_gnt1", instr_gnt_o, 1'b1); chk("t1_rv0", instr_rvalid_o, 1'b1);
        chk("t1_rd0", instr_rdata_o, 32'hA0A0_0000); chk("t1_drv0", data_rvalid_o, 1'b0); adv();
        instr_addr_i = 32'h88; mem_rdata_i = 32'hA0A0_0001;
        at_neg(); chk("t1_gnt2", instr_gnt_o, 1'b1); chk("t1_rv1", instr_rvalid_o, 1'b1); adv();
        instr_req_i = 1'b0; mem_rdata_i = 32'hA0A0_0002;
        at_neg(); chk("t1_rv2", instr_rvalid_o, 1'b1); chk("t1_drv2", data_rvalid_o, 1'b0); adv();
        mem_rvalid_i = 1'b0;

        // Wait-state stability: last grant was INSTR, so data would win without the lock.
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b1;
                data_be_i = 4'h3; data_wdata_i = 32'hDEAD_BEEF;
            end
            at_neg(); chk("t3_addr_hold", mem_addr_o, 32'h100); adv();
        end
        mem_gnt_i = 1'b1;
        at_neg(); chk("t3_instr_first", instr_gnt_o, 1'b1); chk("t3_no_data", data_gnt_o, 1'b0); adv();
        instr_req_i = 1'b0;
        at_neg(); chk("t3_data_next", data_gnt_o, 1'b1); chk("t3_daddr", mem_addr_o, 32'h200); adv();
        data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        at_neg(); chk("t3_rv_i", instr_rvalid_o, 1'b1); adv();
        at_neg(); chk("t3_rv_d", data_rvalid_o, 1'b1); adv();
        mem_rvalid_i = 1'b0;

        // FIFO full: two grants with no responses block the third request.
        instr_req_i = 1'b1; instr_addr_i = 32'h300;
        data_req_i = 1'b1; data_addr_i = 32'h400; data_we_i = 1'b0; mem_gnt_i = 1'b1;
        at_neg(); chk("t4_g1", instr_gnt_o, 1'b1); adv();
        instr_addr_i = 32'h304;
        at_neg(); chk("t4_g2", data_gnt_o, 1'b1); adv();
        for (int k = 0; k < 2; k++) begin
            at_neg(); chk("t4_full_req", mem_req_o, 1'b0); chk("t4_full_busy", busy_o, 1'b1); adv();
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        at_neg(); chk("t4_pop_noreq", mem_req_o, 1'b0); chk("t4_pop_rv", instr_rvalid_o, 1'b1);
        chk("t4_pop_nognt", instr_gnt_o, 1'b0); adv();
        mem_rvalid_i = 1'b0;
        at_neg(); chk("t4_req_back", mem_req_o, 1'b1); chk("t4_gnt_back", instr_gnt_o, 1'b1); adv();
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            at_neg(); adv();
        end
        chk("t4_drained", busy_o, 1'b0);

        // Spurious response with nothing outstanding is dropped.
        at_neg(); chk("t5_spur_i", instr_rvalid_o, 1'b0); chk("t5_spur_d", data_rvalid_o, 1'b0); adv();
        mem_rvalid_i = 1'b0;

        // Reset with two outstanding discards them; a late response is dropped.
        instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1;
        at_neg(); adv();
        at_neg(); adv();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        at_neg(); chk("t5_out2_busy", busy_o, 1'b1);
        rst_i = 1'b1; model_clear();
        #1; chk("t5_rst_busy", busy_o, 1'b0);
        adv();
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        at_neg(); chk("t5_late_i", instr_rvalid_o, 1'b0); chk("t5_late_d", data_rvalid_o, 1'b0); adv();
        mem_rvalid_i = 1'b0;

        // Both requesters held high after reset: grants alternate starting with INSTR.
        instr_req_i = 1'b1; instr_addr_i = 32'h600;
        data_req_i = 1'b1; data_addr_i = 32'h700; data_we_i = 1'b1; data_be_i = 4'hC;
        data_wdata_i = 32'hCAFE_F00D; mem_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("t2_alt_i", instr_gnt_o, (k % 2) == 0);
            chk("t2_alt_d", data_gnt_o, (k % 2) == 1);
            adv();
            mem_rvalid_i = 1'b1;
        end
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            at_neg(); adv();
        end
        mem_rvalid_i = 1'b0;

        // Random traffic obeying OBI: an ungranted request keeps its fields stable.
        last_gi = 1'b0;
        last_gd = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!(instr_req_i && !last_gi)) begin
                instr_req_i  = ($urandom_range(0, 2) != 0);
                instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!(data_req_i && !last_gd)) begin
                data_req_i   = ($urandom_range(0, 2) != 0);
                data_addr_i  = $urandom & 32'hFFFF_FFFC;
                data_we_i    = $urandom_range(0, 1);
                data_be_i    = 4'($urandom_range(0, 15));
                data_wdata_i = $urandom;
            end
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom;
            at_neg();
            last_gi = e_gnt_i;
            last_gd = e_gnt_d;
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Two-to-one OBI arbiter that lets the core's instruction and data ports share a single-ported memory slave port on `mm_ram` or a single-bank memory model. It arbitrates round-robin per transaction, holds the address phase stable until granted, and records the source of every granted request in an in-order FIFO so responses are routed back to the right requester. It sits in the testbench wrapper between `cv32e40p_core` and the memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width on all three ports.
- `DATA_WIDTH`, 32: read/write data width; byte enables are `DATA_WIDTH/8` wide.
- `MAX_OUTSTANDING`, 2: source-FIFO depth (power of two, ≥2); maximum number of granted transactions awaiting `rvalid`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk_i` in 1: clock.
  - `rst_i` in 1: asynchronous, active-high reset.
- Instruction requester (read-only):
  - `instr_req_i` in 1, `instr_gnt_o` out 1, `instr_addr_i` in ADDR_WIDTH: instruction request handshake and address.
  - `instr_rvalid_o` out 1, `instr_rdata_o` out DATA_WIDTH: instruction response.
- Data requester:
  - `data_req_i` in 1, `data_gnt_o` out 1, `data_addr_i` in ADDR_WIDTH, `data_we_i` in 1, `data_be_i` in DATA_WIDTH/8, `data_wdata_i` in DATA_WIDTH: data request.
  - `data_rvalid_o` out 1, `data_rdata_o` out DATA_WIDTH: data response.
- Memory side:
  - `mem_req_o` out 1, `mem_gnt_i` in 1, `mem_addr_o` out ADDR_WIDTH, `mem_we_o` out 1, `mem_be_o` out DATA_WIDTH/8, `mem_wdata_o` out DATA_WIDTH: memory request.
  - `mem_rvalid_i` in 1, `mem_rdata_i` in DATA_WIDTH: memory response.
- Status:
  - `busy_o` out 1: FIFO non-empty or `mem_req_o` high.

## Operation
- Selection: only one requester → that one; both requesting → the source not granted last (`last_src` register).
- Lock state machine with states IDLE and LOCKED:
  - IDLE → LOCKED when `mem_req_o` is high and `mem_gnt_i` is low. The selected source is latched.
  - LOCKED → IDLE on `mem_gnt_i`.
  - While LOCKED, the latched source stays selected regardless of the other request, so OBI address-phase stability holds.
- `mem_req_o` = selected request AND NOT FIFO full. A full FIFO blocks new requests even if a pop happens in the same cycle.
- Request muxing:
  - Instruction selected: `mem_we_o`=0, `mem_be_o`=all ones, `mem_wdata_o`=0.
  - Data selected: the data request fields pass through.
- Grant routing: `instr_gnt_o`/`data_gnt_o` = `mem_gnt_i` AND `mem_req_o` AND (selected == that source). `mem_gnt_i` is ignored when `mem_req_o`=0.
- On a grant:
  - The source ID is pushed to the FIFO.
  - `last_src` is updated to the granted source.
- On `mem_rvalid_i`:
  - Pop the FIFO head.
  - Assert `instr_rvalid_o` or `data_rvalid_o` for the head source only.
  - `mem_rdata_i` drives both `*_rdata_o` unconditionally.
- Push and pop in the same cycle when the FIFO is not full: the count is unchanged and the pointers advance with wrap-around modulo `MAX_OUTSTANDING`.
- `mem_rvalid_i` with an empty FIFO (including a late response after reset): dropped, no `*_rvalid_o` asserted. A simulation assertion flags it.

## Timing
- Request path is combinational, zero latency: `*_req_i` → `mem_req_o`, `mem_gnt_i` → `*_gnt_o`.
- Response routing is combinational from `mem_rvalid_i` using the registered FIFO head; no added latency.
- State updates on the rising edge of `clk_i`:
  - lock state and latched source;
  - `last_src`;
  - FIFO pointers and count.
- Reset values while `rst_i` is high:
  - FIFO empty, state IDLE, `last_src`=DATA (instruction wins the first contention).
  - Outputs: `instr_gnt_o`/`data_gnt_o`/`*_rvalid_o`=0.
  - `mem_req_o` = combinational request; all state is cleared.
- A reset asserted mid-transaction discards outstanding responses.
- Throughput: one grant per cycle when `mem_gnt_i` is held high and the FIFO is not full.

## Structure
- Shared package `obi_arb_pkg`:
  - `typedef enum logic {SRC_INSTR, SRC_DATA} obi_src_e`;
  - `typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e`.
- Sub-module `obi_arb_src_fifo`: parameterised-depth FIFO of `obi_src_e` with push, pop, full, empty and head outputs.
- Top-level contents: selection, lock FSM and muxing.

## Test plan
- Only instructions, `mem_gnt_i`=1, responses 1 cycle later:
  - Stimulus: instr fetches at 0x80, 0x84, 0x88.
  - Response: 3 grants in 3 consecutive cycles; `instr_rvalid_o` with matching rdata; `data_rvalid_o` never high.
- Both requesters held high:
  - Grants alternate INSTR, DATA, INSTR, DATA starting with INSTR after reset.
- Wait-state stability:
  - Stimulus: instr selected with `mem_gnt_i`=0 for 3 cycles; `data_req_i` rises in cycle 2.
  - Response: `mem_addr_o` stays the instr address for all 3 cycles; instr granted first, then data.
- FIFO full:
  - Stimulus: `MAX_OUTSTANDING`=2, two grants, no `rvalid`.
  - Response: `mem_req_o`=0 despite pending requests until the first `mem_rvalid_i`; same-cycle pop does not enable a push.
- Out-of-context and reset:
  - Stimulus: `mem_rvalid_i` with the FIFO empty → no `*_rvalid_o` and the assertion fires.
  - Stimulus: `rst_i` pulsed with 2 outstanding → after reset, a subsequent `mem_rvalid_i` is dropped.
